serial_frame_rx: RTL
====================

// Module: serial_frame_rx
//
// PURPOSE
//   Receiver for the single-bit serial output stream that a module drives on its 1-bit output port.
//   - Oversamples the idle-high line and recovers each frame: start bit, WIDTH data bits (LSB first), optional even-parity bit, stop bit.
//   - Presents each good frame on a one-entry output buffer with a valid/ready handshake.
//   - Sits between a 1-bit serial port and word-wide consumer logic or a test bench.
//
// PARAMETERS
//   WIDTH   8  data bits per frame (1..32)
//   DIV     4  clock cycles per serial bit (even, >=2)
//   PARITY  1  1 = even-parity bit after the data bits; 0 = no parity bit
//
// PORTS
//   clk          in   1      single clock; all state updates on posedge
//   rst_n        in   1      reset, asynchronous, active-low
//   rx_i         in   1      serial line, idle high
//   data_o       out  WIDTH  received word, valid while valid_o=1
//   valid_o      out  1      buffer holds an unconsumed word
//   ready_i      in   1      consumer accepts data_o when valid_o && ready_i
//   parity_err_o out  1      1-cycle pulse: parity mismatch, frame dropped
//   frame_err_o  out  1      1-cycle pulse: stop bit sampled 0, frame dropped
//   overrun_o    out  1      1-cycle pulse: good frame lost, buffer full
//
// BEHAVIOUR
//   Reset
//   - rst_n=0 forces IDLE immediately.
//   - Clears the bit counter, divider, and shift register.
//   - data_o=0, valid_o=0, and all pulse outputs are 0.
//   - A frame in progress is discarded; no outputs fire for it.
//   Divider
//   - Counts 0..DIV-1 and wraps.
//   - Restarts at 0 on the IDLE->START transition.
//   FSM states and transitions
//   - IDLE: rx_i=0 sampled -> START.
//   - START: after DIV/2 cycles, sample rx_i (mid-bit).
//     - 0 -> DATA.
//     - 1 -> IDLE (glitch rejected, no pulse).
//   - DATA: sample every DIV cycles, shifting LSB first; after WIDTH samples -> PARITY if PARITY=1, else STOP.
//   - PARITY: one sample after DIV cycles.
//     - Error if the XOR of the data bits and the parity bit is 1.
//   - STOP: one sample after DIV cycles, then -> IDLE.
//     - The next start bit is accepted from the following cycle.
//   Frame outcome at the stop sample (priority order)
//   - Stop bit = 0: frame_err_o pulses. A parity error is not also reported.
//   - Parity error: parity_err_o pulses.
//   - Otherwise the frame is good.
//   Buffer load (good frame)
//   - If valid_o=0, or valid_o && ready_i in the same cycle: data_o loads and valid_o=1 from the next cycle.
//   - Latency: valid_o rises one cycle after the stop-bit sample edge.
//   - Else (buffer full, not draining): overrun_o pulses, the old data_o is kept, and the new frame is dropped.
//   Handshake
//   - valid_o && ready_i with no simultaneous load -> valid_o=0 next cycle.
//   - data_o is held stable while valid_o=1 and ready_i=0.
//   - ready_i is ignored when valid_o=0.
//   Other rules
//   - No error pulse changes valid_o or data_o.
//   - At most one pulse output is high in any cycle.
//
// TESTING  (WIDTH=8, DIV=4, PARITY=1 unless noted)
//   1. Send frame 0xA5, parity 0, stop 1, with ready_i=1.
//      -> data_o=0xA5; valid_o high exactly 1 cycle, one cycle after the stop-sample edge.
//   2. Send 0x3C then 0x81 back-to-back with ready_i=0, then raise ready_i.
//      -> overrun_o pulses once; data_o stays 0x3C.
//   3. Send 0x01 with parity bit 0.
//      -> parity_err_o 1-cycle pulse; valid_o stays 0.
//   4. Send a frame with stop bit 0.
//      -> frame_err_o pulses; no valid.
//   5. Drive a 1-cycle low glitch on rx_i.
//      -> FSM returns to IDLE; no output activity.
//   6. Assert rst_n=0 mid-DATA, release, then send 0xFF.
//      -> outputs 0 during reset; afterwards data_o=0xFF, valid_o=1.
//   7. With PARITY=0, send 0x7E.
//      -> frame is 10 bit-times; data_o=0x7E.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampling serial frame receiver with one-entry valid/ready output buffer
module serial_frame_rx #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o
);
  localparam int DW = $clog2(DIV);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t           state;
  logic [DW-1:0]    div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             par;
  logic             tick;
  // divider restarts on the start edge, so every sample lands mid-bit
  assign tick = div == DW'(DIV / 2 - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      cnt          <= '0;
      shift        <= '0;
      par          <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
      div          <= (state == IDLE || div == DW'(DIV - 1)) ? '0 : div + 1'b1;
      if (valid_o && ready_i) valid_o <= 1'b0;
      case (state)
        IDLE: if (!rx_i) begin
          state <= START;
          cnt   <= '0;
          par   <= 1'b0;
        end
        START: if (tick) state <= rx_i ? IDLE : DATA;
        DATA: if (tick) begin
          shift <= (shift >> 1) | (WIDTH'(rx_i) << (WIDTH - 1));
          par   <= par ^ rx_i;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= (PARITY != 0) ? PAR : STOP;
        end
        PAR: if (tick) begin
          par   <= par ^ rx_i;
          state <= STOP;
        end
        STOP: if (tick) begin
          state <= IDLE;
          if (!rx_i) frame_err_o <= 1'b1;
          else if (PARITY != 0 && par) parity_err_o <= 1'b1;
          else if (valid_o && !ready_i) overrun_o <= 1'b1;
          else begin
            data_o  <= shift;
            valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
